vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA raster timing from CLOCK_50. Drives the pixel coordinates (xcount, ycount) and the sync outputs (VGA_HS, VGA_VS) that the line/square drawing stage consumes to decide pixel colour. Also provides a pixel-rate tick and line/frame strobes, so downstream animation logic can advance object positions once per frame.

Parameters:
CLK_DIV, 2, clk cycles per pixel; legal range 1..16. The default gives 25 MHz from 50 MHz.
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of VGA_HS
VS_POL, 0, asserted level of VGA_VS

Ports:
clk  in  1  system clock, CLOCK_50; all logic is on the rising edge
rst_n  in  1  synchronous reset, active-low
xcount  out  16  current pixel column, 0..H_TOTAL-1
ycount  out  16  current line, 0..V_TOTAL-1
VGA_HS  out  1  horizontal sync
VGA_VS  out  1  vertical sync
video_active  out  1  high when xcount<H_ACTIVE and ycount<V_ACTIVE
pix_tick  out  1  one-clk pulse on every pixel advance
line_start  out  1  one-clk pulse when xcount becomes 0
frame_start  out  1  one-clk pulse when (xcount,ycount) becomes (0,0)

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525. All compares use 16-bit unsigned arithmetic.
- Clock divider: internal div counter runs 0..CLK_DIV-1 and wraps. pix_tick=1 in the clk cycle where div==CLK_DIV-1. With CLK_DIV=1, pix_tick is high every cycle.
- Counter advance: the counters update on the clk edge that ends a cycle with pix_tick=1. xcount increments; at H_TOTAL-1 it wraps to 0 and ycount increments. ycount wraps from V_TOTAL-1 to 0.
- All outputs are registered. VGA_HS, VGA_VS, video_active, line_start and frame_start are decoded from the next-state counters and registered together with xcount/ycount. They therefore correspond to the xcount/ycount visible in the same cycle, with zero skew.
- VGA_HS = HS_POL when xcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751]; otherwise ~HS_POL.
- VGA_VS = VS_POL when ycount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490, 491]; otherwise ~VS_POL.
- line_start and frame_start are high only in the first clk cycle after the counter update into x=0 (respectively x=0,y=0). They are low on all other cycles, including the remaining CLK_DIV-1 cycles of that pixel.
- Reset (rst_n=0 sampled on a clk edge) sets:
  - div=0, xcount=H_TOTAL-1=799, ycount=V_TOTAL-1=524
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL, video_active=0, pix_tick=0, line_start=0, frame_start=0
  - These values are consistent with the raster position (799,524).
- After reset release: the first pix_tick occurs CLK_DIV cycles later. The following update wraps the counters to (0,0) and pulses frame_start and line_start together. The first frame is therefore complete and aligned.
- Reset mid-frame: the reset takes effect at the next clk edge regardless of div or counter state. No partial sync pulse is held over; HS/VS go to their deasserted levels immediately.
- Frame period = H_TOTAL*V_TOTAL*CLK_DIV = 840000 clk cycles (59.52 Hz at 50 MHz).
- Outputs never take values outside the stated ranges. xcount never reaches H_TOTAL; ycount never reaches V_TOTAL.

Test Plan:
1. Reset: hold rst_n=0 for 3 clks. Expect xcount=799, ycount=524, VGA_HS=1, VGA_VS=1, video_active=0, all pulses 0. Release; at CLK_DIV=2, expect the first pix_tick on the 2nd clk, then xcount=0, ycount=0, frame_start=1 and line_start=1 for exactly one clk.
2. Horizontal timing: across one line, VGA_HS=0 for exactly 96 pixels starting at xcount=656 (192 clks). video_active=1 for xcount 0..639 on a visible line. The line spans 1600 clks.
3. Vertical timing: VGA_VS=0 exactly while ycount is 490..491 (2*1600 clks). video_active=0 for all ycount>=480. ycount wraps 524->0 coincident with frame_start.
4. Frame period: measure consecutive frame_start rising edges = 840000 clks. Count line_start pulses per frame = 525 and pix_tick pulses per frame = 420000.
5. Mid-frame reset: assert rst_n=0 for 1 clk at xcount=700, ycount=100 (inside HS pulse). Next cycle expect VGA_HS=1, xcount=799, ycount=524. Expect frame_start 2 clks after release.
6. CLK_DIV=1, HS_POL=1: pix_tick constantly high. VGA_HS=1 for xcount 656..751 (96 clks). Frame period = 420000 clks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, x/y raster counters and
// registered sync/active/strobe outputs that stay aligned with the counters.
module vga_timing_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] xcount,
  output logic [15:0] ycount,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        video_active,
  output logic        pix_tick,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div, div_nxt;
  logic [15:0]      x_nxt, y_nxt;
  logic             hs_on, vs_on, act_nxt;

  // Counters advance on the edge ending a tick cycle; using the registered
  // tick keeps the post-reset cycle tick-free even when CLK_DIV is 1.
  always_comb begin
    div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;
    x_nxt   = xcount;
    y_nxt   = ycount;
    if (pix_tick) begin
      if (xcount == H_LAST) begin
        x_nxt = '0;
        y_nxt = (ycount == V_LAST) ? '0 : ycount + 16'd1;
      end else begin
        x_nxt = xcount + 16'd1;
      end
    end
    hs_on   = (x_nxt >= HS_BEG) && (x_nxt <= HS_END);
    vs_on   = (y_nxt >= VS_BEG) && (y_nxt <= VS_END);
    act_nxt = (x_nxt < H_ACT) && (y_nxt < V_ACT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div          <= '0;
      pix_tick     <= 1'b0;
      xcount       <= H_LAST;
      ycount       <= V_LAST;
      VGA_HS       <= ~HS_POL;
      VGA_VS       <= ~VS_POL;
      video_active <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      div          <= div_nxt;
      pix_tick     <= (div_nxt == DIV_LAST);
      xcount       <= x_nxt;
      ycount       <= y_nxt;
      VGA_HS       <= hs_on ? HS_POL : ~HS_POL;
      VGA_VS       <= vs_on ? VS_POL : ~VS_POL;
      video_active <= act_nxt;
      line_start   <= pix_tick && (x_nxt == '0);
      frame_start  <= pix_tick && (x_nxt == '0) && (y_nxt == '0);
    end
  end

endmodule
